// File: rtl/draw_cell_highlight.sv
// Two-stage video overlay that paints selected cells of a 3x3 board (solid, blinking or outlined).
// Cell mask and mode are latched at the vblnk rising edge so a frame never tears.
module draw_cell_highlight #(
  parameter int unsigned X0         = 0,
  parameter int unsigned Y0         = 10,
  parameter int unsigned CELL_W     = 339,
  parameter int unsigned CELL_H     = 249,
  parameter int unsigned BORDER     = 8,
  parameter logic [11:0] COLOR      = 12'hff0,
  parameter int unsigned BLINK_HALF = 30
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [8:0]  cell_req,
  input  logic [1:0]  mode_req,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic        frame_tick
);

  localparam int unsigned CW  = 12;
  localparam int unsigned BCW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [CW-1:0]  X_LO     = CW'(X0);
  localparam logic [CW-1:0]  Y_LO     = CW'(Y0);
  localparam logic [CW-1:0]  W_SZ     = CW'(CELL_W);
  localparam logic [CW-1:0]  H_SZ     = CW'(CELL_H);
  localparam logic [CW-1:0]  B_SZ     = CW'(BORDER);
  localparam logic [BCW-1:0] BLINK_MX = BCW'(BLINK_HALF - 1);

  localparam logic [1:0] MODE_SOLID  = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;
  localparam logic [1:0] MODE_BORDER = 2'd3;
  localparam logic [1:0] IDX_NONE    = 2'd3;

  if ((X0 + 3 * CELL_W > 2048) || (Y0 + 3 * CELL_H > 2048) ||
      (2 * BORDER >= CELL_W) || (2 * BORDER >= CELL_H) || (BLINK_HALF < 1)) begin : g_bad_cfg
    $error("draw_cell_highlight: invalid parameter set");
  end

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;
  } timing_t;

  // Returns {edge, index}; index 3 means the coordinate is outside the board on this axis.
  function automatic logic [2:0] axis_decode(input logic [CW-1:0] p, input logic [CW-1:0] lo,
                                             input logic [CW-1:0] size, input logic [CW-1:0] border);
    logic [CW-1:0] base;
    logic [CW-1:0] off;
    logic [1:0]    idx;
    idx  = IDX_NONE;
    off  = '0;
    base = lo;
    for (int i = 0; i < 3; i++) begin
      if ((idx == IDX_NONE) && (p >= base) && (p < base + size)) begin
        idx = 2'(i);
        off = p - base;
      end
      base = base + size;
    end
    return {(off < border) || (off >= size - border), idx};
  endfunction

  timing_t        s1_tim_q, s1_tim_d, s2_tim_q, s2_tim_d;
  logic [11:0]    s1_rgb_q, s1_rgb_d, s2_rgb_q, s2_rgb_d;
  logic [1:0]     s1_col_q, s1_col_d, s1_row_q, s1_row_d;
  logic           s1_edge_q, s1_edge_d;
  logic           vblnk_prev_q, vblnk_prev_d;
  logic [8:0]     cell_act_q, cell_act_d;
  logic [1:0]     mode_act_q, mode_act_d;
  logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
  logic           blink_on_q, blink_on_d;
  logic           frame_tick_q, frame_tick_d;

  logic [2:0]     xdec_c, ydec_c;
  logic           latch_c;
  logic [3:0]     cell_idx_c;
  logic           in_cell_c;
  logic           draw_c;

  always_comb begin
    s1_tim_d     = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                     hblnk: hblnk_in, vsync: vsync_in, vblnk: vblnk_in};
    s1_rgb_d     = rgb_in;
    xdec_c       = axis_decode({1'b0, hcount_in}, X_LO, W_SZ, B_SZ);
    ydec_c       = axis_decode({1'b0, vcount_in}, Y_LO, H_SZ, B_SZ);
    s1_col_d     = xdec_c[1:0];
    s1_row_d     = ydec_c[1:0];
    s1_edge_d    = xdec_c[2] | ydec_c[2];

    vblnk_prev_d = vblnk_in;
    latch_c      = vblnk_in & ~vblnk_prev_q;
    cell_act_d   = cell_act_q;
    mode_act_d   = mode_act_q;
    blink_cnt_d  = blink_cnt_q;
    blink_on_d   = blink_on_q;
    frame_tick_d = latch_c;

    // Frame-boundary latch; the blink phase advances once per frame whatever the mode.
    if (latch_c) begin
      cell_act_d = cell_req;
      mode_act_d = mode_req;
      if (blink_cnt_q == BLINK_MX) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BCW'(1);
      end
    end

    cell_idx_c = 4'(s1_row_q) * 4'd3 + 4'(s1_col_q);
    in_cell_c  = (s1_col_q != IDX_NONE) && (s1_row_q != IDX_NONE);
    draw_c     = in_cell_c && cell_act_q[cell_idx_c] && !s1_tim_q.hblnk && !s1_tim_q.vblnk &&
                 ((mode_act_q == MODE_SOLID) ||
                  ((mode_act_q == MODE_BLINK) && blink_on_q) ||
                  ((mode_act_q == MODE_BORDER) && s1_edge_q));

    s2_tim_d = s1_tim_q;
    s2_rgb_d = draw_c ? COLOR : s1_rgb_q;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_tim_q     <= '0;
      s1_rgb_q     <= '0;
      s1_col_q     <= '0;
      s1_row_q     <= '0;
      s1_edge_q    <= 1'b0;
      s2_tim_q     <= '0;
      s2_rgb_q     <= '0;
      vblnk_prev_q <= 1'b0;
      cell_act_q   <= '0;
      mode_act_q   <= '0;
      blink_cnt_q  <= '0;
      blink_on_q   <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      s1_tim_q     <= s1_tim_d;
      s1_rgb_q     <= s1_rgb_d;
      s1_col_q     <= s1_col_d;
      s1_row_q     <= s1_row_d;
      s1_edge_q    <= s1_edge_d;
      s2_tim_q     <= s2_tim_d;
      s2_rgb_q     <= s2_rgb_d;
      vblnk_prev_q <= vblnk_prev_d;
      cell_act_q   <= cell_act_d;
      mode_act_q   <= mode_act_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_on_q   <= blink_on_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign hcount_out = s2_tim_q.hcount;
  assign vcount_out = s2_tim_q.vcount;
  assign hsync_out  = s2_tim_q.hsync;
  assign hblnk_out  = s2_tim_q.hblnk;
  assign vsync_out  = s2_tim_q.vsync;
  assign vblnk_out  = s2_tim_q.vblnk;
  assign rgb_out    = s2_rgb_q;
  assign frame_tick = frame_tick_q;

endmodule
